// File: rtl/rv32ima_pkg.sv
// Shared RV32 load/store definitions: access widths and the alignment rule
// used by both data- and instruction-side bus masters.
package rv32ima_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } mem_width_t;

  // The reserved encoding 2'b11 behaves as a full word.
  function automatic mem_width_t norm_width(input logic [1:0] w);
    case (w)
      2'b00:   return BYTE;
      2'b01:   return HALF;
      default: return WORD;
    endcase
  endfunction

  function automatic logic is_misaligned(input mem_width_t w, input logic [1:0] addr_lo);
    case (w)
      HALF:    return addr_lo[0];
      WORD:    return (addr_lo != 2'b00);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for a 32-bit bus: store data replication into lanes and
// load data extraction with sign/zero extension. Purely combinational.
module lsu_lane_align
  import rv32ima_pkg::*;
#(
  parameter int BIT_WIDTH = 32
) (
  input  mem_width_t           st_width,
  input  logic [BIT_WIDTH-1:0] st_data,
  output logic [BIT_WIDTH-1:0] st_lanes,
  input  mem_width_t           ld_width,
  input  logic [1:0]           ld_addr_lo,
  input  logic                 ld_unsigned,
  input  logic [BIT_WIDTH-1:0] ld_word,
  output logic [BIT_WIDTH-1:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Replicating across every lane lets the slave's byte enables pick the target.
  always_comb begin
    case (st_width)
      BYTE:    st_lanes = {(BIT_WIDTH/8){st_data[7:0]}};
      HALF:    st_lanes = {(BIT_WIDTH/16){st_data[15:0]}};
      default: st_lanes = st_data;
    endcase
  end

  always_comb begin
    ld_byte = ld_word[{ld_addr_lo, 3'b000} +: 8];
    ld_half = ld_word[{ld_addr_lo[1], 4'b0000} +: 16];
    case (ld_width)
      BYTE:    ld_data = {{(BIT_WIDTH-8){ld_byte[7] & ~ld_unsigned}}, ld_byte};
      HALF:    ld_data = {{(BIT_WIDTH-16){ld_half[15] & ~ld_unsigned}}, ld_half};
      default: ld_data = ld_word;
    endcase
  end

endmodule

// File: rtl/dmem_minibus_master.sv
// Data-side minibus master: takes one load/store from the LSU, runs a single
// sel/ack bus transaction and reports completion, error and load data.
module dmem_minibus_master
  import rv32ima_pkg::*;
#(
  parameter int BIT_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 cpu_req,
  input  logic                 cpu_wen,
  input  logic [BIT_WIDTH-1:0] cpu_addr,
  input  logic [1:0]           cpu_width,
  input  logic                 cpu_unsigned,
  input  logic [BIT_WIDTH-1:0] cpu_wdata,
  output logic                 cpu_ready,
  output logic                 cpu_done,
  output logic                 cpu_err,
  output logic [BIT_WIDTH-1:0] cpu_rdata,
  output logic                 bus_sel,
  output logic                 bus_wen,
  output logic                 bus_ren,
  output logic [BIT_WIDTH-1:0] bus_addr,
  output logic [1:0]           bus_width,
  output logic [BIT_WIDTH-1:0] bus_wdata,
  input  logic [BIT_WIDTH-1:0] bus_rdata,
  input  logic                 bus_ack,
  input  logic                 bus_err,
  output logic [1:0]           dbg_state
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state;
  logic [CNT_W-1:0]     tmo_cnt;
  logic                 req_unsigned;
  mem_width_t           req_width;
  logic                 req_misaligned;
  logic [BIT_WIDTH-1:0] st_lanes;
  logic [BIT_WIDTH-1:0] ld_data;

  // Handshake: a request transfers on a rising edge where cpu_req && cpu_ready;
  // the CPU holds its request fields stable until that edge.
  assign req_width      = norm_width(cpu_width);
  assign req_misaligned = is_misaligned(req_width, cpu_addr[1:0]);
  assign cpu_ready      = (state == IDLE);
  assign dbg_state      = state;

  lsu_lane_align #(
    .BIT_WIDTH (BIT_WIDTH)
  ) u_lane_align (
    .st_width    (req_width),
    .st_data     (cpu_wdata),
    .st_lanes    (st_lanes),
    .ld_width    (mem_width_t'(bus_width)),
    .ld_addr_lo  (bus_addr[1:0]),
    .ld_unsigned (req_unsigned),
    .ld_word     (bus_rdata),
    .ld_data     (ld_data)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state        <= IDLE;
      tmo_cnt      <= '0;
      req_unsigned <= 1'b0;
      bus_sel      <= 1'b0;
      bus_wen      <= 1'b0;
      bus_ren      <= 1'b0;
      bus_addr     <= '0;
      bus_width    <= 2'b00;
      bus_wdata    <= '0;
      cpu_done     <= 1'b0;
      cpu_err      <= 1'b0;
      cpu_rdata    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_req) begin
            if (req_misaligned) begin
              state    <= DONE;
              cpu_done <= 1'b1;
              cpu_err  <= 1'b1;
            end else begin
              state        <= REQ;
              tmo_cnt      <= '0;
              req_unsigned <= cpu_unsigned;
              bus_sel      <= 1'b1;
              bus_wen      <= cpu_wen;
              bus_ren      <= ~cpu_wen;
              bus_addr     <= cpu_addr;
              bus_width    <= req_width;
              bus_wdata    <= st_lanes;
            end
          end
        end
        REQ: begin
          // Ack has priority over a timeout landing in the same cycle.
          if (bus_ack) begin
            state    <= DONE;
            bus_sel  <= 1'b0;
            bus_wen  <= 1'b0;
            bus_ren  <= 1'b0;
            cpu_done <= 1'b1;
            cpu_err  <= bus_err;
            if (bus_ren && !bus_err) begin
              cpu_rdata <= ld_data;
            end
          end else if (tmo_cnt == CNT_LAST) begin
            state    <= DONE;
            bus_sel  <= 1'b0;
            bus_wen  <= 1'b0;
            bus_ren  <= 1'b0;
            cpu_done <= 1'b1;
            cpu_err  <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
          end
        end
        DONE: begin
          // Bus stays idle here so the slave's registered ack clears first.
          state    <= IDLE;
          cpu_done <= 1'b0;
          cpu_err  <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_minibus_master.sv
// Bench for dmem_minibus_master: behavioural RAM slave on the bus, byte-level
// reference memory for expectations, directed cases then random traffic.
module tb_dmem_minibus_master;

  localparam int BW  = 32;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic          cpu_req, cpu_wen, cpu_unsigned;
  logic [BW-1:0] cpu_addr, cpu_wdata;
  logic [1:0]    cpu_width;
  logic          cpu_ready, cpu_done, cpu_err;
  logic [BW-1:0] cpu_rdata;
  logic          bus_sel, bus_wen, bus_ren;
  logic [BW-1:0] bus_addr, bus_wdata;
  logic [1:0]    bus_width;
  logic [BW-1:0] bus_rdata;
  logic          bus_ack, bus_err;
  logic [1:0]    dbg_state;

  // clock / reset
  always #5 clk = ~clk;

  dmem_minibus_master #(
    .BIT_WIDTH      (BW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk          (clk),
    .nrst         (nrst),
    .cpu_req      (cpu_req),
    .cpu_wen      (cpu_wen),
    .cpu_addr     (cpu_addr),
    .cpu_width    (cpu_width),
    .cpu_unsigned (cpu_unsigned),
    .cpu_wdata    (cpu_wdata),
    .cpu_ready    (cpu_ready),
    .cpu_done     (cpu_done),
    .cpu_err      (cpu_err),
    .cpu_rdata    (cpu_rdata),
    .bus_sel      (bus_sel),
    .bus_wen      (bus_wen),
    .bus_ren      (bus_ren),
    .bus_addr     (bus_addr),
    .bus_width    (bus_width),
    .bus_wdata    (bus_wdata),
    .bus_rdata    (bus_rdata),
    .bus_ack      (bus_ack),
    .bus_err      (bus_err),
    .dbg_state    (dbg_state)
  );

  // RAM slave: registered ack one cycle after select; mode 0 ok, 1 error, 2 never acks
  logic [31:0] slave_mem [64] = '{default: 32'h0};
  int          slave_mode = 0;
  logic [3:0]  slave_be;

  always_comb begin
    case (bus_width)
      2'b00:   slave_be = 4'b0001 << bus_addr[1:0];
      2'b01:   slave_be = bus_addr[1] ? 4'b1100 : 4'b0011;
      default: slave_be = 4'b1111;
    endcase
  end

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      bus_ack   <= 1'b0;
      bus_err   <= 1'b0;
      bus_rdata <= '0;
    end else begin
      bus_ack <= 1'b0;
      bus_err <= 1'b0;
      if (bus_sel && !bus_ack && slave_mode != 2) begin
        bus_ack   <= 1'b1;
        bus_err   <= (slave_mode == 1);
        bus_rdata <= slave_mem[bus_addr[7:2]];
        if (bus_wen && slave_mode == 0) begin
          for (int i = 0; i < 4; i++) begin
            if (slave_be[i]) slave_mem[bus_addr[7:2]][8*i +: 8] <= bus_wdata[8*i +: 8];
          end
        end
      end
    end
  end

  // scoreboard state
  int          n_checks = 0;
  int          n_errors = 0;
  logic [7:0]  ref_bytes [256];
  logic [31:0] last_rd;
  logic [BW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_load(input int addr, input int sz, input logic uns);
    logic [31:0] v;
    v = 32'h0;
    for (int i = 0; i < sz; i++) v = v | (32'(ref_bytes[addr + i]) << (8 * i));
    if (!uns && sz < 4 && v[8*sz-1]) v = v | ~((32'd1 << (8 * sz)) - 32'd1);
    return v;
  endfunction

  task automatic wait_ready();
    int c;
    c = 0;
    while (!cpu_ready && c < 20) begin
      @(negedge clk);
      c++;
    end
    check("ready_before_req", 32'(cpu_ready), 32'd1);
  endtask

  // driver: one request, then follow it to completion
  task automatic do_op(input logic wen, input logic [31:0] addr, input logic [1:0] width,
                       input logic uns, input logic [31:0] wdata, input int mode);
    int sz, idx, c, sel_n, done_c, exp_done, exp_sel;
    logic mis, ok, exp_err, got_err, got_wen, got_ren;
    logic [31:0] got_rd, got_addr, got_wdata, exp_lanes, exp_val;
    logic [1:0] got_width;
    sz  = (width == 2'b00) ? 1 : (width == 2'b01) ? 2 : 4;
    idx = int'(addr[7:0]);
    mis = (idx % sz) != 0;
    ok  = !mis && (mode == 0);
    if (mis) begin
      exp_done = 1; exp_sel = 0; exp_err = 1'b1;
    end else if (mode == 2) begin
      exp_done = TMO + 1; exp_sel = TMO; exp_err = 1'b1;
    end else begin
      exp_done = 3; exp_sel = 2; exp_err = (mode == 1);
    end
    if (!wen && ok) exp_q.push_back(ref_load(idx, sz, uns));
    exp_lanes = (sz == 1) ? {4{wdata[7:0]}} : (sz == 2) ? {2{wdata[15:0]}} : wdata;

    slave_mode = mode;
    wait_ready();
    cpu_req = 1'b1; cpu_wen = wen; cpu_addr = addr; cpu_width = width;
    cpu_unsigned = uns; cpu_wdata = wdata;
    @(negedge clk);
    cpu_req = 1'b0;
    c = 1; sel_n = 0; done_c = 0;
    got_err = 1'b0; got_rd = cpu_rdata; got_addr = '0; got_wdata = '0;
    got_wen = 1'b0; got_ren = 1'b0; got_width = 2'b00;
    while (done_c == 0 && c <= TMO + 8) begin
      if (bus_sel) begin
        sel_n++;
        got_addr = bus_addr; got_wdata = bus_wdata; got_width = bus_width;
        got_wen = bus_wen; got_ren = bus_ren;
      end
      if (cpu_done) begin
        done_c = c; got_err = cpu_err; got_rd = cpu_rdata;
      end else begin
        @(negedge clk);
        c++;
      end
    end
    check("done_latency", 32'(done_c), 32'(exp_done));
    check("sel_cycles", 32'(sel_n), 32'(exp_sel));
    if (done_c != 0) begin
      check("cpu_err", 32'(got_err), 32'(exp_err));
      check("ready_in_done", 32'(cpu_ready), 32'd0);
    end
    if (sel_n > 0) begin
      check("bus_addr", got_addr, addr);
      check("bus_wen", 32'(got_wen), 32'(wen));
      check("bus_ren", 32'(got_ren), 32'(!wen));
      if (width != 2'b11) check("bus_width", 32'(got_width), 32'(width));
      if (wen) check("bus_wdata", got_wdata, exp_lanes);
    end
    if (!wen && ok) begin
      exp_val = exp_q.pop_front();
      check("load_data", got_rd, exp_val);
      last_rd = exp_val;
    end else if (!ok) begin
      check("rdata_hold", got_rd, last_rd);
    end
    if (wen && ok) begin
      for (int i = 0; i < sz; i++) ref_bytes[idx + i] = wdata[8*i +: 8];
    end
    if (done_c != 0) begin
      @(negedge clk);
      check("done_is_pulse", 32'(cpu_done), 32'd0);
      check("ready_after", 32'(cpu_ready), 32'd1);
    end
    slave_mode = 0;
  endtask

  task automatic back_to_back();
    int rises, fall_c, rise2_c, dones;
    logic prev_sel;
    rises = 0; fall_c = -1; rise2_c = -1; dones = 0; prev_sel = 1'b0;
    wait_ready();
    cpu_req = 1'b1; cpu_wen = 1'b0; cpu_addr = 32'h10; cpu_width = 2'b10; cpu_unsigned = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (bus_sel && !prev_sel) begin
        rises++;
        if (rises == 2) begin
          rise2_c = c;
          cpu_req = 1'b0;
        end
      end
      if (!bus_sel && prev_sel && fall_c < 0) fall_c = c;
      if (cpu_done) dones++;
      prev_sel = bus_sel;
    end
    cpu_req = 1'b0;
    last_rd = ref_load(32'h10, 4, 1'b0);
    check("b2b_rises", 32'(rises), 32'd2);
    check("b2b_gap_ge2", 32'(rise2_c - fall_c >= 2 && fall_c > 0), 32'd1);
    check("b2b_dones", 32'(dones), 32'd2);
    check("b2b_rdata", cpu_rdata, last_rd);
  endtask

  task automatic reset_mid_req();
    int dones;
    dones = 0;
    wait_ready();
    cpu_req = 1'b1; cpu_wen = 1'b0; cpu_addr = 32'h20; cpu_width = 2'b10; cpu_unsigned = 1'b0;
    @(negedge clk);
    cpu_req = 1'b0;
    check("rst_pre_sel", 32'(bus_sel), 32'd1);
    nrst = 1'b0;
    #1;
    check("rst_bus_sel", 32'(bus_sel), 32'd0);
    check("rst_bus_ren", 32'(bus_ren), 32'd0);
    check("rst_bus_addr", bus_addr, 32'h0);
    check("rst_cpu_ready", 32'(cpu_ready), 32'd1);
    check("rst_cpu_rdata", cpu_rdata, 32'h0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 1) nrst = 1'b1;
      if (cpu_done) dones++;
    end
    check("rst_no_done", 32'(dones), 32'd0);
    last_rd = 32'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        r_wen, r_uns;
    logic [1:0]  r_width;
    logic [31:0] r_addr;
    int          r_sz, r_mode;
    cpu_req = 1'b0; cpu_wen = 1'b0; cpu_addr = '0; cpu_width = 2'b00;
    cpu_unsigned = 1'b0; cpu_wdata = '0;
    for (int i = 0; i < 256; i++) ref_bytes[i] = 8'h00;
    last_rd = 32'h0;

    repeat (3) @(negedge clk);
    check("reset_ready", 32'(cpu_ready), 32'd1);
    check("reset_sel", 32'(bus_sel), 32'd0);
    check("reset_wen", 32'(bus_wen), 32'd0);
    check("reset_done", 32'(cpu_done), 32'd0);
    check("reset_err", 32'(cpu_err), 32'd0);
    check("reset_rdata", cpu_rdata, 32'h0);
    check("reset_wdata", bus_wdata, 32'h0);
    check("reset_width", 32'(bus_width), 32'd0);
    nrst = 1'b1;
    @(negedge clk);

    // directed cases
    do_op(1'b1, 32'h10, 2'b10, 1'b0, 32'hDEAD_BEEF, 0);
    do_op(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 0);
    check("word_load_const", last_rd, 32'hDEAD_BEEF);
    do_op(1'b1, 32'h10, 2'b10, 1'b0, 32'h80FF_1234, 0);
    do_op(1'b0, 32'h13, 2'b00, 1'b0, 32'h0, 0);
    check("lb_signed_const", last_rd, 32'hFFFF_FF80);
    do_op(1'b0, 32'h13, 2'b00, 1'b1, 32'h0, 0);
    check("lbu_const", last_rd, 32'h0000_0080);
    do_op(1'b0, 32'h12, 2'b01, 1'b0, 32'h0, 0);
    check("lh_signed_const", last_rd, 32'hFFFF_80FF);
    do_op(1'b1, 32'h20, 2'b10, 1'b0, 32'h1122_3344, 0);
    do_op(1'b1, 32'h21, 2'b00, 1'b0, 32'h0000_00A5, 0);
    do_op(1'b0, 32'h20, 2'b10, 1'b0, 32'h0, 0);
    check("byte_merge_const", last_rd, 32'h1122_A544);
    do_op(1'b0, 32'h06, 2'b10, 1'b0, 32'h0, 0);
    do_op(1'b0, 32'h13, 2'b01, 1'b0, 32'h0, 0);
    do_op(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 2);
    do_op(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 1);
    do_op(1'b1, 32'h10, 2'b01, 1'b0, 32'h0000_5555, 1);
    back_to_back();
    reset_mid_req();

    // random traffic
    for (int n = 0; n < 80; n++) begin
      r_wen   = 1'($urandom_range(0, 1));
      r_uns   = 1'($urandom_range(0, 1));
      r_width = 2'($urandom_range(0, 3));
      r_addr  = 32'($urandom_range(0, 255));
      r_sz    = (r_width == 2'b00) ? 1 : (r_width == 2'b01) ? 2 : 4;
      if ($urandom_range(0, 3) != 0) r_addr = r_addr & ~32'(r_sz - 1);
      r_mode  = ($urandom_range(0, 19) == 0) ? 2 : ($urandom_range(0, 9) == 0) ? 1 : 0;
      do_op(r_wen, r_addr, r_width, r_uns, $urandom, r_mode);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dmem_minibus_master.md
Name: dmem_minibus_master

Overview:
- Upstream master for the on-chip RAM minibus slave; sits between the CPU load/store unit and the minibus.
- Accepts one CPU data request at a time and runs a single minibus transaction (sel + ren/wen, wait for ack).
- Aligns store data to byte lanes; extracts, sign- or zero-extends load data.
- Flags misaligned accesses, slave errors and ack timeouts.

Parameters:
- BIT_WIDTH, 32, address/data width.
- TIMEOUT_CYCLES, 16, bus cycles to wait for ack before aborting with error; minimum 2.

Ports:
- clk  in  1  clock, all state on rising edge.
- nrst  in  1  asynchronous active-low reset.
- cpu_req  in  1  request valid; sampled only while cpu_ready=1.
- cpu_wen  in  1  1=store, 0=load.
- cpu_addr  in  BIT_WIDTH  byte address.
- cpu_width  in  2  00 byte, 01 half, 10 word; 11 treated as word.
- cpu_unsigned  in  1  load zero-extend (LBU/LHU); ignored for stores.
- cpu_wdata  in  BIT_WIDTH  store data, right-justified.
- cpu_ready  out  1  master idle, request accepted this cycle.
- cpu_done  out  1  one-cycle completion pulse.
- cpu_err  out  1  valid with cpu_done: misaligned, slave err or timeout.
- cpu_rdata  out  BIT_WIDTH  extended load data, valid with cpu_done, held until next done.
- bus_sel  out  1  slave select.
- bus_wen / bus_ren  out  1 each  minibus write/read enable.
- bus_addr  out  BIT_WIDTH  registered address.
- bus_width  out  2  registered width.
- bus_wdata  out  BIT_WIDTH  lane-aligned store data.
- bus_rdata  in  BIT_WIDTH  full word from slave.
- bus_ack  in  1  slave acknowledge.
- bus_err  in  1  slave error, sampled with ack.

Behaviour:
- Reset (async, nrst=0): state IDLE; bus_sel/wen/ren=0, bus_addr/wdata/width=0, cpu_done=0, cpu_err=0, cpu_rdata=0, timeout counter=0. cpu_ready=1 (decoded from IDLE). Reset mid-transaction aborts it; no done pulse.
- States: IDLE, REQ, DONE.
- IDLE: cpu_req sampled.
  - Aligned request -> REQ; bus outputs registered, visible next cycle.
  - Misaligned (half with addr[0]=1, word with addr[1:0]!=0) -> DONE with cpu_done=1, cpu_err=1 next cycle; no bus activity, cpu_rdata unchanged.
- REQ: bus_sel=1, wen/ren per op, all bus outputs held stable; counter increments each cycle.
  - bus_ack=1 -> capture data, drop sel/wen/ren next cycle, go DONE, cpu_done=1 and cpu_err=bus_err next cycle.
  - Counter reaches TIMEOUT_CYCLES-1 without ack -> drop bus, DONE with cpu_err=1.
  - Ack and timeout in the same cycle: ack wins.
- DONE: one mandatory bus-idle cycle so the slave's registered ready clears before any new select; cpu_ready=0; return to IDLE.
- Nominal latency against the RAM slave: accept at cycle N, sel at N+1, ack at N+2, cpu_done at N+3, cpu_ready again at N+4. Peak throughput 1 per 4 cycles.
- Store alignment:
  - byte: wdata[7:0] replicated in all 4 lanes.
  - half: wdata[15:0] replicated in both halves.
  - word: passthrough.
  - Slave byteen selects the lane.
- Load extraction:
  - byte lane = addr[1:0]; half lane = addr[1].
  - Sign-extend from bit 7/15 unless cpu_unsigned; word passthrough.
  - On any error cpu_rdata keeps its previous value.
- cpu_req while cpu_ready=0 is ignored; the CPU holds it.

Decomposition:
- rv32ima_pkg gains mem_width_t (BYTE=2'b00, HALF=2'b01, WORD=2'b10) and the misalignment check function.
- FSM state enum stays local.
- One combinational sub-module, lsu_lane_align:
  - store replication and load extract/extend.
  - Reused later by the instruction-side master.

Test Plan:
- Aligned word store addr 0x0000_0010, wdata 0xDEADBEEF -> bus_sel/wen high 2 cycles; cpu_done 3 cycles after accept, err=0; word load of 0x10 returns 0xDEADBEEF.
- Signed byte load addr 0x13 from word 0x80FF_1234 -> cpu_rdata 0xFFFF_FF80; unsigned -> 0x0000_0080; half load addr 0x12 signed -> 0xFFFF_80FF.
- Byte store 0xA5 to addr 0x21 -> bus_wdata 0xA5A5_A5A5; later word read of 0x20 shows only byte 1 changed.
- Misaligned word load addr 0x06 -> no bus_sel ever; cpu_done=1, cpu_err=1 one cycle after accept.
- Slave holds ack=0 -> bus dropped after 16 REQ cycles; cpu_done with err=1; slave bus_err=1 with ack -> cpu_err=1.
- Back-to-back requests with cpu_req held high -> second bus_sel rises no earlier than 2 cycles after first drops. nrst pulsed during REQ -> all outputs at reset values, no cpu_done.
